bcd_scan_display: RTL and testbench

Multiplexed four-digit seven-segment driver for the MM:SS timekeeping chain. It sits directly downstream of the BCD mod-60 seconds/minutes counters and consumes their packed-BCD outputs plus the seconds carry. It scans one digit at a time with a guard cycle between digits and latches a coherent snapshot of both inputs once per frame, so the display never tears. It also blinks a colon on each seconds carry and blanks a leading minutes zero.

---
 rtl/bcd_scan_display_if.sv | 22 ++
 rtl/bcd_scan_display.sv | 143 ++++++++++++++
 tb/tb_bcd_scan_display.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus between the MM:SS counter chain and the four-digit scan driver.
// The master side supplies time and enable; the slave side drives the display pins.
interface bcd_scan_display_if;
    logic       en;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       sec_tick;
    logic [3:0] dig_sel;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    modport master (
        output en, sec_bcd, min_bcd, sec_tick,
        input  dig_sel, seg, dp, frame_start
    );

    modport slave (
        input  en, sec_bcd, min_bcd, sec_tick,
        output dig_sel, seg, dp, frame_start
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Multiplexed four-digit seven-segment driver for an MM:SS display.
// One digit is lit per slot, and each slot begins with a dark guard cycle.
// Both BCD inputs are captured together once per frame, so a frame never
// mixes old and new time values. A colon toggles on every seconds carry,
// and a leading minutes zero can be blanked.
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_scan_display_if.slave bus
);
    localparam int                CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [7:0]       sh_sec;
    logic [7:0]       sh_min;
    logic             load_pending;
    logic             colon_on;
    logic             sec_tick_d;
    logic             wrap_d;

    logic             slot_end;
    logic             frame_wrap;
    logic             first_load;

    logic [3:0]       nib_p0;
    logic [3:0]       dig_sel_p0;
    logic [6:0]       seg_p0;
    logic             dp_p0;
    logic             frame_start_p0;

    // Nibble to active-low segments; anything above 9 shows a lone dash.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
    endfunction

    assign slot_end   = (cnt == CNT_MAX);
    assign frame_wrap = bus.en && slot_end && (idx == 2'd3);
    assign first_load = bus.en && load_pending;

    // Slot counter and digit index advance only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (bus.en) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Snapshot both inputs at the frame wrap or on the first enabled cycle after reset.
    // wrap_d remembers a wrap across a disable so its frame_start is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_sec       <= 8'h00;
            sh_min       <= 8'h00;
            load_pending <= 1'b1;
            wrap_d       <= 1'b0;
        end else begin
            if (frame_wrap || first_load) begin
                sh_sec <= bus.sec_bcd;
                sh_min <= bus.min_bcd;
            end
            if (first_load)
                load_pending <= 1'b0;
            if (bus.en)
                wrap_d <= frame_wrap;
        end
    end

    // Colon toggles on each rising edge of the seconds carry, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_tick_d <= 1'b0;
            colon_on   <= 1'b1;
        end else begin
            sec_tick_d <= bus.sec_tick;
            if (bus.sec_tick && !sec_tick_d)
                colon_on <= ~colon_on;
        end
    end

    // Stage p0: next output values derived from the current scan state.
    always_comb begin
        nib_p0         = 4'h0;
        dig_sel_p0     = 4'b1111;
        seg_p0         = 7'h7F;
        dp_p0          = 1'b1;
        frame_start_p0 = bus.en && (load_pending || wrap_d);
        case (idx)
            2'd0:    nib_p0 = sh_sec[3:0];
            2'd1:    nib_p0 = sh_sec[7:4];
            2'd2:    nib_p0 = sh_min[3:0];
            default: nib_p0 = sh_min[7:4];
        endcase
        if (bus.en && (cnt != '0)) begin
            dig_sel_p0        = 4'b1111;
            dig_sel_p0[idx]   = 1'b0;
            if (BLANK_LZ && (idx == 2'd3) && (sh_min[7:4] == 4'h0))
                seg_p0 = 7'h7F;
            else
                seg_p0 = seg7(nib_p0);
            if (idx == 2'd2)
                dp_p0 = ~colon_on;
        end
    end

    // Stage p1: registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dig_sel     <= 4'b1111;
            bus.seg         <= 7'h7F;
            bus.dp          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.dig_sel     <= dig_sel_p0;
            bus.seg         <= seg_p0;
            bus.dp          <= dp_p0;
            bus.frame_start <= frame_start_p0;
        end
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with a four-cycle slot (16-cycle frame).
// Two instances share the stimulus: dut_a blanks the leading minutes zero,
// dut_b does not. Edge E<k> is the k-th rising clock edge after reset release.
module tb_bcd_scan_display;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic [7:0] sec_bcd = 8'h37;
    logic [7:0] min_bcd = 8'h05;
    logic       sec_tick = 1'b0;

    int total = 0;
    int bad   = 0;
    int ecount = 0;

    bcd_scan_display_if ifa ();
    bcd_scan_display_if ifb ();

    assign ifa.en = en;  assign ifa.sec_bcd = sec_bcd;  assign ifa.min_bcd = min_bcd;  assign ifa.sec_tick = sec_tick;
    assign ifb.en = en;  assign ifb.sec_bcd = sec_bcd;  assign ifb.min_bcd = min_bcd;  assign ifb.sec_tick = sec_tick;

    bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic to_edge(input int t);
        while (ecount < t) step();
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_dig"}, {4'h0, ifa.dig_sel}, 8'h0F);
        chk({tag, "_seg"}, {1'b0, ifa.seg}, 8'h7F);
        chk({tag, "_dp"},  {7'h0, ifa.dp}, 8'h01);
    endtask

    initial begin
        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        chk_dark("rst");
        chk("rst_fs", {7'h0, ifa.frame_start}, 8'h00);
        step(); step();
        rst_n  = 1'b1;
        ecount = 0;

        // First load and first frame
        to_edge(1);  chk("e1_fs", {7'h0, ifa.frame_start}, 8'h01);
                     chk("e1_guard", {4'h0, ifa.dig_sel}, 8'h0F);
        to_edge(2);  chk("e2_dig", {4'h0, ifa.dig_sel}, 8'h0E);
                     chk("e2_seg", {1'b0, ifa.seg}, 8'h78);
                     chk("e2_fs", {7'h0, ifa.frame_start}, 8'h00);
        to_edge(4);  chk("e4_dig", {4'h0, ifa.dig_sel}, 8'h0E);
        to_edge(5);  chk("e5_guard", {4'h0, ifa.dig_sel}, 8'h0F);
                     chk("e5_seg", {1'b0, ifa.seg}, 8'h7F);
        to_edge(6);  chk("e6_dig", {4'h0, ifa.dig_sel}, 8'h0D);
                     chk("e6_seg", {1'b0, ifa.seg}, 8'h30);
        to_edge(10); chk("e10_dig", {4'h0, ifa.dig_sel}, 8'h0B);
                     chk("e10_seg", {1'b0, ifa.seg}, 8'h12);
                     chk("e10_dp", {7'h0, ifa.dp}, 8'h00);
        to_edge(14); chk("e14_dig", {4'h0, ifa.dig_sel}, 8'h07);
                     chk("e14_lz_seg", {1'b0, ifa.seg}, 8'h7F);
                     chk("e14_nolz_seg", {1'b0, ifb.seg}, 8'h40);
                     chk("e14_dp", {7'h0, ifa.dp}, 8'h01);
        to_edge(16); chk("e16_fs", {7'h0, ifa.frame_start}, 8'h00);
        to_edge(17); chk("e17_fs", {7'h0, ifa.frame_start}, 8'h01);
        to_edge(18); chk("e18_seg", {1'b0, ifa.seg}, 8'h78);

        // Mid-frame input change stays hidden until the next snapshot
        to_edge(22);
        sec_bcd = 8'h38;
        min_bcd = 8'h07;
        to_edge(26); chk("e26_min_old", {1'b0, ifa.seg}, 8'h12);
        to_edge(33); chk("e33_fs", {7'h0, ifa.frame_start}, 8'h01);
        to_edge(34); chk("e34_sec_new", {1'b0, ifa.seg}, 8'h00);

        // Invalid BCD nibble
        sec_bcd = 8'h5A;
        to_edge(38); chk("e38_tens", {1'b0, ifa.seg}, 8'h30);
        to_edge(42); chk("e42_min_new", {1'b0, ifa.seg}, 8'h78);
        to_edge(49); chk("e49_fs", {7'h0, ifa.frame_start}, 8'h01);
        to_edge(50); chk("e50_dash", {1'b0, ifa.seg}, 8'h3F);
        to_edge(54); chk("e54_tens5", {1'b0, ifa.seg}, 8'h12);

        // Colon toggling
        to_edge(58); chk("e58_dp_on", {7'h0, ifa.dp}, 8'h00);
        sec_tick = 1'b1;
        step();      sec_tick = 1'b0;
        to_edge(60); chk("e60_dp_off", {7'h0, ifa.dp}, 8'h01);
        sec_tick = 1'b1;
        step();      sec_tick = 1'b0;
        to_edge(74); chk("e74_dp_on", {7'h0, ifa.dp}, 8'h00);
        sec_tick = 1'b1;
        to_edge(76); chk("e76_dp_off", {7'h0, ifa.dp}, 8'h01);
        to_edge(78); chk("e78_nolz_seg", {1'b0, ifb.seg}, 8'h40);
        to_edge(84); sec_tick = 1'b0;
        to_edge(90); chk("e90_hold_dp", {7'h0, ifa.dp}, 8'h01);
        to_edge(92); chk("e92_hold_dp", {7'h0, ifa.dp}, 8'h01);

        // Enable drop in the middle of digit 1's slot
        to_edge(97); chk("e97_fs", {7'h0, ifa.frame_start}, 8'h01);
        to_edge(102); chk("e102_dig", {4'h0, ifa.dig_sel}, 8'h0D);
        en = 1'b0;
        to_edge(103); chk_dark("e103_off");
        to_edge(107); chk_dark("e107_off");
                      chk("e107_fs", {7'h0, ifa.frame_start}, 8'h00);
        en = 1'b1;
        to_edge(108); chk("e108_dig", {4'h0, ifa.dig_sel}, 8'h0D);
        to_edge(109); chk("e109_dig", {4'h0, ifa.dig_sel}, 8'h0D);
        to_edge(110); chk("e110_guard", {4'h0, ifa.dig_sel}, 8'h0F);
        to_edge(111); chk("e111_dig", {4'h0, ifa.dig_sel}, 8'h0B);
        to_edge(117); chk("e117_fs", {7'h0, ifa.frame_start}, 8'h00);
        to_edge(118); chk("e118_fs", {7'h0, ifa.frame_start}, 8'h01);

        // Asynchronous reset while digit 2 is lit
        to_edge(127); chk("e127_dig", {4'h0, ifa.dig_sel}, 8'h0B);
        rst_n   = 1'b0;
        sec_bcd = 8'h12;
        min_bcd = 8'h34;
        #1;
        chk_dark("arst");
        chk("arst_fs", {7'h0, ifa.frame_start}, 8'h00);
        step(); step();
        rst_n  = 1'b1;
        ecount = 0;
        to_edge(1);  chk("r1_fs", {7'h0, ifa.frame_start}, 8'h01);
        to_edge(2);  chk("r2_seg", {1'b0, ifa.seg}, 8'h24);
        to_edge(6);  chk("r6_seg", {1'b0, ifa.seg}, 8'h79);
        to_edge(10); chk("r10_seg", {1'b0, ifa.seg}, 8'h19);
                     chk("r10_dp", {7'h0, ifa.dp}, 8'h00);
        to_edge(14); chk("r14_seg", {1'b0, ifa.seg}, 8'h30);
                     chk("r14_nolz_seg", {1'b0, ifb.seg}, 8'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
